// File: rtl/csr_pkg.sv
// Shared definitions for the CSR commit unit: CSR addresses, exception codes,
// field positions and the writeback CSR bus layout.
package csr_pkg;

   localparam int unsigned CSR_ADDR_W = 14;
   localparam int unsigned WCSR_BUS_W = 153;

   // Writeback CSR bus field offsets
   localparam int unsigned WCSR_EX_BIT    = 152;
   localparam int unsigned WCSR_ECODE_LSB = 144;
   localparam int unsigned WCSR_ESUB_BIT  = 143;
   localparam int unsigned WCSR_WE_BIT    = 142;
   localparam int unsigned WCSR_ADDR_LSB  = 128;
   localparam int unsigned WCSR_WMASK_LSB = 96;
   localparam int unsigned WCSR_WDATA_LSB = 64;
   localparam int unsigned WCSR_PC_LSB    = 32;
   localparam int unsigned WCSR_VADDR_LSB = 0;

   localparam logic [CSR_ADDR_W-1:0] CSR_CRMD   = 14'h000;
   localparam logic [CSR_ADDR_W-1:0] CSR_PRMD   = 14'h001;
   localparam logic [CSR_ADDR_W-1:0] CSR_ECFG   = 14'h004;
   localparam logic [CSR_ADDR_W-1:0] CSR_ESTAT  = 14'h005;
   localparam logic [CSR_ADDR_W-1:0] CSR_ERA    = 14'h006;
   localparam logic [CSR_ADDR_W-1:0] CSR_BADV   = 14'h007;
   localparam logic [CSR_ADDR_W-1:0] CSR_EENTRY = 14'h00C;
   localparam logic [CSR_ADDR_W-1:0] CSR_SAVE0  = 14'h030;
   localparam logic [CSR_ADDR_W-1:0] CSR_SAVE1  = 14'h031;
   localparam logic [CSR_ADDR_W-1:0] CSR_SAVE2  = 14'h032;
   localparam logic [CSR_ADDR_W-1:0] CSR_SAVE3  = 14'h033;
   localparam logic [CSR_ADDR_W-1:0] CSR_TID    = 14'h040;
   localparam logic [CSR_ADDR_W-1:0] CSR_TCFG   = 14'h041;
   localparam logic [CSR_ADDR_W-1:0] CSR_TVAL   = 14'h042;
   localparam logic [CSR_ADDR_W-1:0] CSR_TICLR  = 14'h044;

   localparam logic [7:0] ECODE_INT  = 8'h00;
   localparam logic [7:0] ECODE_ADE  = 8'h08;
   localparam logic [7:0] ECODE_ALE  = 8'h09;
   localparam logic [7:0] ECODE_TLBR = 8'h3F;

   localparam int unsigned CRMD_W      = 5;
   localparam int unsigned CRMD_IE     = 2;
   localparam int unsigned CRMD_DA     = 3;
   localparam int unsigned PRMD_W      = 3;
   localparam int unsigned IS_W        = 13;
   localparam int unsigned IS_TI       = 11;
   localparam int unsigned ECFG_W      = 13;
   localparam logic [ECFG_W-1:0] ECFG_LIE_MASK = 13'h1BFF;
   localparam int unsigned EENTRY_LSB  = 6;
   localparam int unsigned TCFG_EN     = 0;
   localparam int unsigned TCFG_PERIOD = 1;

   typedef struct packed {
      logic        ex;
      logic [7:0]  ecode;
      logic        esubcode;
      logic        csr_we;
      logic [CSR_ADDR_W-1:0] csr_addr;
      logic [31:0] wmask;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic [31:0] vaddr;
   } wcsr_bus_t;

   // Exceptions that carry a faulting virtual address into BADV
   function automatic logic badv_ecode(input logic [7:0] e);
      return ((e >= 8'h01) && (e <= ECODE_ALE)) || (e == ECODE_TLBR);
   endfunction

endpackage

// File: rtl/csr_timer.sv
// Constant timer: owns TCFG (En, Periodic, InitVal) and TVAL; fires for one
// cycle whenever an enabled timer sits at zero.
module csr_timer
   import csr_pkg::*;
#(
   parameter int unsigned TIMER_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tcfg_we,
   input  logic [TIMER_W-1:0] tcfg_wdata,
   output logic [TIMER_W-1:0] tcfg,
   output logic [TIMER_W-1:0] tval,
   output logic               timer_fire
);

   logic [TIMER_W-1:0] tcfg_q, tcfg_d;
   logic [TIMER_W-1:0] tval_q, tval_d;

   // A write takes precedence over both reload and decrement
   always_comb begin
      tcfg_d     = tcfg_q;
      tval_d     = tval_q;
      timer_fire = tcfg_q[TCFG_EN] && (tval_q == '0);
      if (tcfg_we) begin
         tcfg_d = tcfg_wdata;
         tval_d = {tcfg_wdata[TIMER_W-1:2], 2'b00};
      end else if (timer_fire) begin
         if (tcfg_q[TCFG_PERIOD]) tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
         else                     tcfg_d[TCFG_EN] = 1'b0;
      end else if (tcfg_q[TCFG_EN]) begin
         tval_d = tval_q - TIMER_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tcfg_q <= '0;
         tval_q <= '0;
      end else begin
         tcfg_q <= tcfg_d;
         tval_q <= tval_d;
      end
   end

   assign tcfg = tcfg_q;
   assign tval = tval_q;

endmodule

// File: rtl/csr_commit_unit.sv
// Architectural CSR file with exception/ertn commit, flush/redirect and
// interrupt pending. Timer CSRs exist only when CSR_TIMER_EN is defined.
module csr_commit_unit
   import csr_pkg::*;
#(
   parameter int unsigned TIMER_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WCSR_BUS_W-1:0] Wcsr_BUS,
   input  logic                  ertn_W,
   input  logic [7:0]            hw_int_in,
   input  logic [CSR_ADDR_W-1:0] csr_raddr,
   output logic [31:0]           csr_rdata,
   output logic                  ex_en,
   output logic [31:0]           ex_entry,
   output logic                  has_int,
   output logic [1:0]            crmd_plv
);

`ifdef CSR_TIMER_EN
   localparam bit HAS_TIMER = 1'b1;
`else
   localparam bit HAS_TIMER = 1'b0;
`endif

   wcsr_bus_t bus;
   assign bus = Wcsr_BUS;

   logic [CRMD_W-1:0] crmd_q, crmd_d;
   logic [PRMD_W-1:0] prmd_q, prmd_d;
   logic [ECFG_W-1:0] ecfg_q, ecfg_d;
   logic [1:0]        is_sw_q, is_sw_d;
   logic [7:0]        is_hw_q, is_hw_d;
   logic              is_ti_q, is_ti_d;
   logic [5:0]        ecode_q, ecode_d;
   logic [8:0]        esub_q, esub_d;
   logic [31:0]       era_q, era_d;
   logic [31:0]       badv_q, badv_d;
   logic [31-EENTRY_LSB:0] eentry_q, eentry_d;
   logic [31:0]       save_q [4];
   logic [31:0]       save_d [4];
   logic [31:0]       tid_q, tid_d;

   logic [IS_W-1:0]    is_c;
   logic [31:0]        wr_old, wr_val;
   logic               wr_en;
   logic               tcfg_we;
   logic [TIMER_W-1:0] tcfg_wdata;
   logic [TIMER_W-1:0] tcfg, tval;
   logic               timer_fire;

   assign is_c = {1'b0, is_ti_q, 1'b0, is_hw_q, is_sw_q};

   function automatic logic [31:0] read_csr(input logic [CSR_ADDR_W-1:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         CSR_CRMD:   r = 32'(crmd_q);
         CSR_PRMD:   r = 32'(prmd_q);
         CSR_ECFG:   r = 32'(ecfg_q);
         CSR_ESTAT:  r = {1'b0, esub_q, ecode_q, 3'b000, is_c};
         CSR_ERA:    r = era_q;
         CSR_BADV:   r = badv_q;
         CSR_EENTRY: r = {eentry_q, 6'b0};
         CSR_SAVE0:  r = save_q[0];
         CSR_SAVE1:  r = save_q[1];
         CSR_SAVE2:  r = save_q[2];
         CSR_SAVE3:  r = save_q[3];
         CSR_TID:    r = HAS_TIMER ? tid_q : '0;
         CSR_TCFG:   r = 32'(tcfg);
         CSR_TVAL:   r = 32'(tval);
         default:    r = '0;
      endcase
      return r;
   endfunction

   // Read port for decode, and the old value seen by a masked write
   always_comb begin
      csr_rdata = read_csr(csr_raddr);
      wr_old    = read_csr(bus.csr_addr);
   end

   assign wr_en      = bus.csr_we & ~bus.ex;
   assign wr_val     = (wr_old & ~bus.wmask) | (bus.wdata & bus.wmask);
   assign tcfg_wdata = TIMER_W'(wr_val);

   // Next-state: software write first, then ex/ertn override the fields they own
   always_comb begin
      crmd_d   = crmd_q;
      prmd_d   = prmd_q;
      ecfg_d   = ecfg_q;
      is_sw_d  = is_sw_q;
      is_hw_d  = hw_int_in;
      is_ti_d  = is_ti_q;
      ecode_d  = ecode_q;
      esub_d   = esub_q;
      era_d    = era_q;
      badv_d   = badv_q;
      eentry_d = eentry_q;
      save_d   = save_q;
      tid_d    = tid_q;
      tcfg_we  = 1'b0;

      if (wr_en) begin
         case (bus.csr_addr)
            CSR_CRMD:   crmd_d   = wr_val[CRMD_W-1:0];
            CSR_PRMD:   prmd_d   = wr_val[PRMD_W-1:0];
            CSR_ECFG:   ecfg_d   = wr_val[ECFG_W-1:0] & ECFG_LIE_MASK;
            CSR_ESTAT:  is_sw_d  = wr_val[1:0];
            CSR_ERA:    era_d    = wr_val;
            CSR_BADV:   badv_d   = wr_val;
            CSR_EENTRY: eentry_d = wr_val[31:EENTRY_LSB];
            CSR_SAVE0:  save_d[0] = wr_val;
            CSR_SAVE1:  save_d[1] = wr_val;
            CSR_SAVE2:  save_d[2] = wr_val;
            CSR_SAVE3:  save_d[3] = wr_val;
            CSR_TID:    if (HAS_TIMER) tid_d = wr_val;
            CSR_TCFG:   tcfg_we = HAS_TIMER;
            CSR_TICLR:  if (HAS_TIMER && wr_val[0]) is_ti_d = 1'b0;
            default:    ;
         endcase
      end

      // Expiry beats a same-cycle clear
      if (timer_fire) is_ti_d = 1'b1;

      if (bus.ex) begin
         prmd_d      = crmd_q[PRMD_W-1:0];
         crmd_d[2:0] = 3'b000;
         era_d       = bus.pc;
         ecode_d     = bus.ecode[5:0];
         esub_d      = 9'(bus.esubcode);
         if (badv_ecode(bus.ecode)) badv_d = bus.vaddr;
      end else if (ertn_W) begin
         crmd_d[2:0] = prmd_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crmd_q   <= 5'(1 << CRMD_DA);
         prmd_q   <= '0;
         ecfg_q   <= '0;
         is_sw_q  <= '0;
         is_hw_q  <= '0;
         is_ti_q  <= 1'b0;
         ecode_q  <= '0;
         esub_q   <= '0;
         era_q    <= '0;
         badv_q   <= '0;
         eentry_q <= '0;
         for (int i = 0; i < 4; i++) save_q[i] <= '0;
         tid_q    <= '0;
      end else begin
         crmd_q   <= crmd_d;
         prmd_q   <= prmd_d;
         ecfg_q   <= ecfg_d;
         is_sw_q  <= is_sw_d;
         is_hw_q  <= is_hw_d;
         is_ti_q  <= is_ti_d;
         ecode_q  <= ecode_d;
         esub_q   <= esub_d;
         era_q    <= era_d;
         badv_q   <= badv_d;
         eentry_q <= eentry_d;
         save_q   <= save_d;
         tid_q    <= tid_d;
      end
   end

`ifdef CSR_TIMER_EN
   csr_timer #(
      .TIMER_W (TIMER_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .tcfg_we    (tcfg_we),
      .tcfg_wdata (tcfg_wdata),
      .tcfg       (tcfg),
      .tval       (tval),
      .timer_fire (timer_fire)
   );
`else
   assign tcfg       = '0;
   assign tval       = '0;
   assign timer_fire = 1'b0;
   logic unused_timer;
   assign unused_timer = ^{tcfg_we, tcfg_wdata};
`endif

   assign ex_en    = bus.ex | ertn_W;
   assign ex_entry = bus.ex ? {eentry_q, 6'b0} : era_q;
   assign has_int  = (|(is_c & ecfg_q)) & crmd_q[CRMD_IE];
   assign crmd_plv = crmd_q[1:0];

endmodule

// File: tb/tb_csr_commit_unit.sv
// Self-checking bench for csr_commit_unit: CSR reads are scoreboarded, flush
// outputs checked in-cycle. Timer checks run when CSR_TIMER_EN is defined.
module tb_csr_commit_unit;

   localparam logic [13:0] A_CRMD = 14'h000, A_PRMD = 14'h001, A_ECFG = 14'h004,
                           A_ESTAT = 14'h005, A_ERA = 14'h006, A_BADV = 14'h007,
                           A_EENTRY = 14'h00C, A_SAVE0 = 14'h030, A_SAVE1 = 14'h031,
                           A_TID = 14'h040, A_TCFG = 14'h041, A_TVAL = 14'h042,
                           A_TICLR = 14'h044;

   logic         clk = 1'b0;
   logic         rst;
   logic [152:0] Wcsr_BUS;
   logic         ertn_W;
   logic [7:0]   hw_int_in;
   logic [13:0]  csr_raddr;
   logic [31:0]  csr_rdata;
   logic         ex_en;
   logic [31:0]  ex_entry;
   logic         has_int;
   logic [1:0]   crmd_plv;

   int n_chk = 0;
   int n_bad = 0;

   typedef struct {
      string       tag;
      logic [13:0] addr;
      logic [31:0] exp;
   } exp_t;
   exp_t sb_q[$];

   csr_commit_unit #(.TIMER_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .Wcsr_BUS  (Wcsr_BUS),
      .ertn_W    (ertn_W),
      .hw_int_in (hw_int_in),
      .csr_raddr (csr_raddr),
      .csr_rdata (csr_rdata),
      .ex_en     (ex_en),
      .ex_entry  (ex_entry),
      .has_int   (has_int),
      .crmd_plv  (crmd_plv)
   );

   always #10 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic expect_csr(input string tag, input logic [13:0] a, input logic [31:0] e);
      exp_t x;
      x.tag = tag; x.addr = a; x.exp = e;
      sb_q.push_back(x);
   endtask

   task automatic drain();
      exp_t x;
      while (sb_q.size() > 0) begin
         x = sb_q.pop_front();
         csr_raddr = x.addr;
         #1;
         chk(x.tag, csr_rdata, x.exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] m, input logic [31:0] d);
      return (o & ~m) | (d & m);
   endfunction

   task automatic drive_bus(input logic ex, input logic [7:0] ec, input logic es,
                            input logic we, input logic [13:0] a, input logic [31:0] m,
                            input logic [31:0] d, input logic [31:0] pc, input logic [31:0] va);
      Wcsr_BUS = {ex, ec, es, we, a, m, d, pc, va};
   endtask

   // Drives one write for the next edge; caller is away from the edge
   task automatic csr_wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] d);
      drive_bus(1'b0, 8'h0, 1'b0, 1'b1, a, m, d, 32'h0, 32'h0);
      @(posedge clk); #1;
      Wcsr_BUS = '0;
   endtask

   initial begin
      logic found;
      rst = 1'b1; Wcsr_BUS = '0; ertn_W = 1'b0; hw_int_in = 8'h00; csr_raddr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("rst_has_int", 32'(has_int), 32'h0);
      chk("rst_ex_en", 32'(ex_en), 32'h0);
      chk("rst_plv", 32'(crmd_plv), 32'h0);
      expect_csr("rst_crmd", A_CRMD, 32'h8);
      expect_csr("rst_estat", A_ESTAT, 32'h0);
      expect_csr("rst_prmd", A_PRMD, 32'h0);
      drain();

      // masked write
      csr_wr(A_SAVE1, 32'hFFFFFFFF, 32'hAAAAAAAA);
      csr_wr(A_SAVE1, 32'h0000FFFF, 32'h12345678);
      csr_wr(A_CRMD, 32'hFFFFFFFF, 32'h00000007);
      csr_wr(A_EENTRY, 32'hFFFFFFFF, 32'h1C00013F);
      @(negedge clk);
      expect_csr("save1_mask", A_SAVE1, merge(32'hAAAAAAAA, 32'h0000FFFF, 32'h12345678));
      expect_csr("save1_const", A_SAVE1, 32'hAAAA5678);
      expect_csr("crmd_wr", A_CRMD, 32'h7);
      expect_csr("eentry_lowbits", A_EENTRY, 32'h1C000100);
      drain();

      // exception commit
      drive_bus(1'b1, 8'h09, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h1C0000F0, 32'h00000003);
      #1;
      chk("ex_en_ex", 32'(ex_en), 32'h1);
      chk("ex_entry_ex", ex_entry, 32'h1C000100);
      @(posedge clk); #1; Wcsr_BUS = '0;
      @(negedge clk);
      chk("ex_plv", 32'(crmd_plv), 32'h0);
      expect_csr("ex_crmd", A_CRMD, 32'h0);
      expect_csr("ex_prmd", A_PRMD, 32'h7);
      expect_csr("ex_era", A_ERA, 32'h1C0000F0);
      expect_csr("ex_badv", A_BADV, 32'h3);
      expect_csr("ex_estat", A_ESTAT, 32'h00090000);
      drain();

      // ertn
      ertn_W = 1'b1;
      #1;
      chk("ertn_ex_en", 32'(ex_en), 32'h1);
      chk("ertn_entry", ex_entry, 32'h1C0000F0);
      @(posedge clk); #1; ertn_W = 1'b0;
      @(negedge clk);
      chk("ertn_plv", 32'(crmd_plv), 32'h3);
      expect_csr("ertn_crmd", A_CRMD, 32'h7);
      drain();

      // exception beats same-cycle write; ecode 0x0E leaves BADV alone
      drive_bus(1'b1, 8'h0E, 1'b1, 1'b1, A_SAVE0, 32'hFFFFFFFF, 32'h55, 32'h1C000200, 32'h0000DEAD);
      #1;
      chk("exwe_entry", ex_entry, 32'h1C000100);
      @(posedge clk); #1; Wcsr_BUS = '0;
      @(negedge clk);
      expect_csr("exwe_save0", A_SAVE0, 32'h0);
      expect_csr("exwe_badv", A_BADV, 32'h3);
      expect_csr("exwe_era", A_ERA, 32'h1C000200);
      expect_csr("exwe_prmd", A_PRMD, 32'h7);
      expect_csr("exwe_estat", A_ESTAT, 32'h004E0000);
      expect_csr("exwe_crmd", A_CRMD, 32'h0);
      drain();

      // hardware interrupt lines and ECFG/IE gating
      hw_int_in = 8'hA5;
      @(posedge clk); @(negedge clk);
      chk("hw_noenable", 32'(has_int), 32'h0);
      expect_csr("hw_estat", A_ESTAT, 32'h004E0294);
      drain();
      csr_wr(A_ECFG, 32'hFFFFFFFF, 32'h00001FFF);
      csr_wr(A_CRMD, 32'h00000004, 32'h00000004);
      @(negedge clk);
      chk("hw_has_int", 32'(has_int), 32'h1);
      expect_csr("ecfg_rsvd", A_ECFG, 32'h00001BFF);
      expect_csr("crmd_ie", A_CRMD, 32'h4);
      drain();
      hw_int_in = 8'h00;
      @(posedge clk); @(negedge clk);
      chk("hw_drop", 32'(has_int), 32'h0);
      csr_wr(A_ESTAT, 32'hFFFFFFFF, 32'hFFFFFFFF);
      @(negedge clk);
      chk("sw_has_int", 32'(has_int), 32'h1);
      expect_csr("estat_sw", A_ESTAT, 32'h004E0003);
      drain();
      csr_wr(A_ESTAT, 32'hFFFFFFFF, 32'h0);
      csr_wr(A_ECFG, 32'hFFFFFFFF, 32'h00000800);

`ifdef CSR_TIMER_EN
      csr_wr(A_TCFG, 32'hFFFFFFFF, 32'h0000000B);
      @(negedge clk);
      expect_csr("tcfg_rd", A_TCFG, 32'hB);
      drain();
      for (int k = 0; k <= 8; k++) begin
         chk("tmr_no_int", 32'(has_int), 32'h0);
         expect_csr("tval_count", A_TVAL, 32'(8 - k));
         drain();
         @(negedge clk);
      end
      chk("tmr_has_int", 32'(has_int), 32'h1);
      expect_csr("tmr_is11", A_ESTAT, 32'h004E0800);
      expect_csr("tmr_reload", A_TVAL, 32'h8);
      drain();
      csr_wr(A_TICLR, 32'hFFFFFFFF, 32'h1);
      @(negedge clk);
      chk("ticlr_int", 32'(has_int), 32'h0);
      expect_csr("ticlr_is11", A_ESTAT, 32'h004E0000);
      drain();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         csr_raddr = A_TVAL;
         #1;
         if (csr_rdata == 32'h0) found = 1'b1;
         else @(negedge clk);
      end
      chk("tval_zero_seen", 32'(found), 32'h1);
      csr_wr(A_TICLR, 32'hFFFFFFFF, 32'h1);
      @(negedge clk);
      expect_csr("clr_vs_fire", A_ESTAT, 32'h004E0800);
      expect_csr("clr_vs_reload", A_TVAL, 32'h8);
      drain();
      // one-shot: En drops and TVAL holds 0
      csr_wr(A_TCFG, 32'hFFFFFFFF, 32'h00000009);
      repeat (12) @(negedge clk);
      expect_csr("oneshot_tcfg", A_TCFG, 32'h8);
      expect_csr("oneshot_tval", A_TVAL, 32'h0);
      drain();
      csr_wr(A_TID, 32'hFFFFFFFF, 32'h00001234);
      csr_wr(A_TCFG, 32'hFFFFFFFF, 32'h0000000B);
      @(negedge clk);
      expect_csr("tid_rd", A_TID, 32'h1234);
      drain();
      repeat (3) @(negedge clk);
`else
      csr_wr(A_TCFG, 32'hFFFFFFFF, 32'h0000000B);
      csr_wr(A_TID, 32'hFFFFFFFF, 32'h00001234);
      csr_wr(A_TICLR, 32'hFFFFFFFF, 32'h1);
      repeat (12) @(negedge clk);
      chk("notmr_int", 32'(has_int), 32'h0);
      expect_csr("notmr_tcfg", A_TCFG, 32'h0);
      expect_csr("notmr_tid", A_TID, 32'h0);
      expect_csr("notmr_tval", A_TVAL, 32'h0);
      expect_csr("notmr_estat", A_ESTAT, 32'h004E0000);
      drain();
`endif

      // single-cycle reset mid-operation
      hw_int_in = 8'hFF;
      @(negedge clk);
      rst = 1'b1; hw_int_in = 8'h00;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst2_has_int", 32'(has_int), 32'h0);
      chk("rst2_ex_en", 32'(ex_en), 32'h0);
      expect_csr("rst2_crmd", A_CRMD, 32'h8);
      expect_csr("rst2_estat", A_ESTAT, 32'h0);
      expect_csr("rst2_tval", A_TVAL, 32'h0);
      expect_csr("rst2_tcfg", A_TCFG, 32'h0);
      expect_csr("rst2_save1", A_SAVE1, 32'h0);
      drain();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/csr_commit_unit.md
# csr_commit_unit

Consumer end of the writeback-stage CSR bus. It holds the architectural control/status registers and applies CSR writes retired by writeback. It commits exceptions and `ertn`, and drives the pipeline flush (`ex_en`) and redirect target back to every stage. It also owns the constant timer and the interrupt-pending logic feeding decode.

## Interface
Parameters:
- `TIMER_W`, default 32: width of TVAL and of the timer reload value.

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  core clock
- `rst`  in  1  synchronous active-high reset
- `Wcsr_BUS`  in  153  from writeback:
  - [152] ex, valid-qualified
  - [151:144] ecode
  - [143] esubcode
  - [142] csr_we, valid-qualified
  - [141:128] csr_addr
  - [127:96] wmask
  - [95:64] wdata
  - [63:32] pc
  - [31:0] vaddr
- `ertn_W`  in  1  valid, non-excepting `ertn` retired in writeback
- `hw_int_in`  in  8  level hardware interrupt lines
- `csr_raddr`  in  14  read address from decode
- `csr_rdata`  out  32  combinational read data; unimplemented address reads 0
- `ex_en`  out  1  flush pulse = ex | ertn_W, combinational
- `ex_entry`  out  32  redirect PC: EENTRY if ex, else ERA
- `has_int`  out  1  |(ESTAT.IS[12:0] & ECFG.LIE[12:0]) & CRMD.IE
- `crmd_plv`  out  2  current privilege, for fetch and memory checks

## Operation
- Implemented CSRs and addresses:
  - CRMD 0x0: PLV[1:0], IE[2], DA[3] (resets to 1), PG[4]
  - PRMD 0x1: PPLV[1:0], PIE[2]
  - ECFG 0x4: LIE[12:0], but bit 10 is reserved and reads 0
  - ESTAT 0x5: IS[12:0], Ecode[21:16], EsubCode[30:22]
  - ERA 0x6, BADV 0x7
  - EENTRY 0xC: VA[31:6]; low bits read 0
  - SAVE0–3 0x30–0x33
  - TID 0x40, TCFG 0x41 (En[0], Periodic[1], InitVal[TIMER_W-1:2]), TVAL 0x42 (read-only)
  - TICLR 0x44: write-1 to bit 0; reads 0
- CSR write: new = (old & ~wmask) | (wdata & wmask), restricted to writable fields. Only ESTAT.IS[1:0] is software-writable.
- Exception commit (ex=1):
  - PRMD ← {CRMD.IE, CRMD.PLV}; CRMD.PLV ← 0, IE ← 0
  - ERA ← pc; ESTAT.Ecode ← ecode[5:0]; EsubCode ← esubcode
  - BADV ← vaddr only for ecode 0x1–0x9 or 0x3F; otherwise BADV is unchanged
- ertn commit: CRMD.PLV ← PRMD.PPLV, CRMD.IE ← PRMD.PIE.
- Simultaneous events:
  - If ex and csr_we are both set in one cycle, ex wins and the CSR write is dropped.
  - ex and ertn_W together is illegal; ex has priority.
- ESTAT.IS[9:2] ← hw_int_in every cycle.

## Timing
- All register updates take effect at the clk edge of commit. `csr_rdata` shows the new value the cycle after.
- `ex_en` and `ex_entry` are combinational, with zero latency from `Wcsr_BUS`. Writeback samples `ex_en` in the same cycle.
- `ex_entry` on ertn uses the ERA value before any same-cycle write.
- Reset values:
  - CRMD = 0x8 (DA=1)
  - All other CSRs 0; TCFG.En = 0
  - Outputs: `ex_en`=0, `has_int`=0, `crmd_plv`=0
- Timer, when TCFG.En=1: TVAL decrements by 1 every cycle. On the cycle TVAL==0:
  - IS[11] ← 1
  - If Periodic, TVAL ← {InitVal,2'b00}
  - Otherwise TCFG.En ← 0 and TVAL holds 0
- Timer side effects:
  - A TCFG write loads TVAL ← {new InitVal,2'b00} next cycle.
  - A TICLR clear and a timer expiry in the same cycle leave IS[11]=1 (expiry wins).
- Reset mid-operation clears the timer and any pending interrupt in one cycle.

## Configuration
- `CSR_TIMER_EN` defined: TID/TCFG/TVAL/TICLR are implemented as above.
- Not defined:
  - Those addresses read 0 and ignore writes.
  - IS[11] is tied 0.
  - The timer sub-module is not instantiated.

## Structure
- Shared package `csr_pkg`:
  - CSR address localparams (CSR_CRMD … CSR_TICLR)
  - Ecode constants (ECODE_INT, ECODE_ADE=0x8, ECODE_ALE=0x9, ECODE_TLBR=0x3F)
  - Field bit positions
  - `Wcsr_BUS` field offsets and width
- One sub-module, `csr_timer`:
  - Owns TVAL, En and Periodic
  - Inputs: TCFG write strobe and data
  - Outputs: TVAL and a one-cycle `timer_fire`

## Test plan
- Reset, then read CRMD → 0x8; ESTAT → 0; `has_int`=0; `ex_en`=0.
- CSR write to SAVE1: wmask 0x0000FFFF, wdata 0x12345678, old 0xAAAAAAAA → SAVE1 = 0xAAAA5678.
- Exception:
  - Setup: CRMD=0x7, EENTRY=0x1C000100.
  - Stimulus: ex with ecode 0x9, pc 0x1C0000F0, vaddr 0x00000003.
  - Same cycle: `ex_en`=1, `ex_entry`=0x1C000100.
  - Next cycle: CRMD.PLV=0, IE=0; PRMD=0x7; ERA=0x1C0000F0; BADV=0x3; ESTAT.Ecode=0x9.
- ertn after the exception:
  - Same cycle: `ex_entry`=0x1C0000F0.
  - Next cycle: CRMD.PLV=3, IE=1.
- Exception with a same-cycle CSR write:
  - Stimulus: ex=1 and csr_we=1 to SAVE0 with wdata 0x55.
  - Response: SAVE0 is unchanged.
- Timer (CSR_TIMER_EN):
  - Setup: TCFG=0x0B (InitVal field 2, periodic, En) with ECFG.LIE[11]=1 and CRMD.IE=1. TVAL loads 8 and counts 8…0.
  - Response: IS[11] and `has_int` go to 1 and TVAL reloads 8.
  - TICLR write 1 → IS[11]=0 the next cycle. When the TICLR clear coincides with expiry, IS[11] stays 1.
